msrv32_dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory bus.
- Accepts load and store requests issued by the core's load/store path, including the byte write mask and write-request qualification.
- Services them from an internal word-organised RAM with a programmable number of wait states.
- Returns read data, a ready indication and a one-cycle response strobe, with an error flag for out-of-range addresses.

---
 rtl/msrv32_dmem_responder.sv | 184 ++++++++++++++++++
 tb/tb_msrv32_dmem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_dmem_responder.sv
// -----------------------------------------------------------------------------
// msrv32_dmem_responder
//
// Memory-side responder for the core's data-memory bus. Requests from the
// core's load/store path are accepted whenever the responder is ready. Each
// request is serviced from an internal word-organised RAM after a fixed number
// of wait states. Completion is marked with a one-cycle response strobe,
// together with the read word and an out-of-range error flag.
//
// Parameters
//   ADDR_W       word-address width, RAM depth is 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states between acceptance and the RAM access (0..15)
//
// Ports
//   ms_riscv32_mp_clk_in   system clock, rising edge
//   ms_riscv32_mp_rst_in   synchronous active-high reset
//   dm_req_in              request valid, sampled only while dm_hready_out=1
//   dm_wr_req_in           1 = store, 0 = load
//   dm_addr_in             byte address, bits [1:0] ignored
//   dm_wr_data_in          lane-aligned store data
//   dm_wr_mask_in          byte-lane write enables
//   dm_rd_data_out         full read word of the most recent load
//   dm_hready_out          1 = a request can be accepted this cycle
//   dm_rsp_valid_out       one-cycle completion strobe
//   dm_err_out             out-of-range flag, valid with dm_rsp_valid_out
// -----------------------------------------------------------------------------
module msrv32_dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        dm_req_in,
    input  logic        dm_wr_req_in,
    input  logic [31:0] dm_addr_in,
    input  logic [31:0] dm_wr_data_in,
    input  logic [3:0]  dm_wr_mask_in,
    output logic [31:0] dm_rd_data_out,
    output logic        dm_hready_out,
    output logic        dm_rsp_valid_out,
    output logic        dm_err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    // Access-edge view of the request: either the held copy (after wait
    // states) or the live inputs (zero-wait access at the acceptance edge).
    logic              access;
    logic              acc_wr;
    logic [29:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_mask;
    logic              acc_oor;
    logic [ADDR_W-1:0] acc_idx;
    logic              mem_we;

    // The byte offset inside a word has no meaning for a word-wide RAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^dm_addr_in[1:0];

    assign dm_hready_out    = (state_q != BUSY);
    assign dm_rd_data_out   = rd_data_q;
    assign dm_rsp_valid_out = rsp_valid_q;
    assign dm_err_out       = err_q;

    assign acc_idx = acc_addr[ADDR_W-1:0];
    assign acc_oor = ((acc_addr >> ADDR_W) != '0);

    // A store is committed only at its access edge, so a reset arriving on
    // that edge must still block the write.
    assign mem_we = access && acc_wr && !acc_oor && !ms_riscv32_mp_rst_in;

    // Next-state, request capture and response computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rd_data_d   = rd_data_q;
        access      = 1'b0;
        acc_wr      = wr_q;
        acc_addr    = addr_q;
        acc_wdata   = wdata_q;
        acc_mask    = mask_q;

        case (state_q)
            IDLE, DONE: begin
                if (dm_req_in) begin
                    addr_d  = dm_addr_in[31:2];
                    wr_d    = dm_wr_req_in;
                    wdata_d = dm_wr_data_in;
                    mask_d  = dm_wr_mask_in;
                    if (WAIT_CYCLES == 0) begin
                        access    = 1'b1;
                        acc_wr    = dm_wr_req_in;
                        acc_addr  = dm_addr_in[31:2];
                        acc_wdata = dm_wr_data_in;
                        acc_mask  = dm_wr_mask_in;
                        state_d   = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = access;
        err_d       = access && acc_oor;

        // Stores leave the read register alone; out-of-range loads read zero.
        if (access && !acc_wr) begin
            rd_data_d = acc_oor ? 32'd0 : mem[acc_idx];
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'd0;
            mask_q      <= 4'd0;
            rd_data_q   <= 32'd0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    // RAM contents survive reset; only enabled byte lanes are written.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_msrv32_dmem_responder
//
// Drives two responders side by side: instance 0 with two wait states and
// instance 1 with none. A plain word-array model of each RAM predicts load
// data, error flags and response timing for directed and random traffic.
// -----------------------------------------------------------------------------
module tb_msrv32_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  mask  [2];
    logic [31:0] rd    [2];
    logic        hready[2];
    logic        rsp   [2];
    logic        err   [2];

    logic [31:0] model_mem [2][1024];
    logic [31:0] model_rd  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msrv32_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut_w2 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .dm_req_in            (req[0]),
        .dm_wr_req_in         (wr[0]),
        .dm_addr_in           (addr[0]),
        .dm_wr_data_in        (wdata[0]),
        .dm_wr_mask_in        (mask[0]),
        .dm_rd_data_out       (rd[0]),
        .dm_hready_out        (hready[0]),
        .dm_rsp_valid_out     (rsp[0]),
        .dm_err_out           (err[0])
    );

    msrv32_dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .dm_req_in            (req[1]),
        .dm_wr_req_in         (wr[1]),
        .dm_addr_in           (addr[1]),
        .dm_wr_data_in        (wdata[1]),
        .dm_wr_mask_in        (mask[1]),
        .dm_rd_data_out       (rd[1]),
        .dm_hready_out        (hready[1]),
        .dm_rsp_valid_out     (rsp[1]),
        .dm_err_out           (err[1])
    );

    // One complete access on instance d, starting in a cycle where it is
    // ready. Returns #1 after the edge that enters the response cycle, with
    // the request already withdrawn, so the caller may issue back-to-back.
    task automatic do_access(input int d, input logic w, input logic [31:0] a,
                             input logic [31:0] dat, input logic [3:0] m,
                             input string tag);
        int          nw;
        logic        oor;
        logic [9:0]  idx;
        logic [31:0] exp_rd;
        logic [31:0] prev_rd;
        nw      = (d == 0) ? 2 : 0;
        oor     = (a[31:12] != 20'd0);
        idx     = a[11:2];
        prev_rd = model_rd[d];
        if (w) begin
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) model_mem[d][idx][8*i +: 8] = dat[8*i +: 8];
                end
            end
            exp_rd = prev_rd;
        end else begin
            exp_rd = oor ? 32'd0 : model_mem[d][idx];
        end
        model_rd[d] = exp_rd;

        total++;
        if (hready[d] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s ready_before: got %b want 1", tag, hready[d]);
        end
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = dat; mask[d] = m;
        @(posedge clk);
        for (int k = 1; k <= nw + 1; k++) begin
            #1;
            if (k <= nw) begin
                total++;
                if (hready[d] !== 1'b0 || rsp[d] !== 1'b0 || rd[d] !== prev_rd) begin
                    bad++;
                    $display("[TB] FAIL %s busy%0d: got hready=%b rsp=%b rd=%h want 0 0 %h",
                             tag, k, hready[d], rsp[d], rd[d], prev_rd);
                end
                // Junk requests while busy must be ignored.
                req[d]   = 1'b1;
                wr[d]    = 1'b1;
                addr[d]  = 32'($urandom_range(0, 15)) << 2;
                wdata[d] = $urandom;
                mask[d]  = 4'hF;
                @(posedge clk);
            end else begin
                total++;
                if (rsp[d] !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL %s rsp_valid: got %b want 1", tag, rsp[d]);
                end
                total++;
                if (err[d] !== oor) begin
                    bad++;
                    $display("[TB] FAIL %s err: got %b want %b", tag, err[d], oor);
                end
                total++;
                if (rd[d] !== exp_rd) begin
                    bad++;
                    $display("[TB] FAIL %s rd_data: got %h want %h", tag, rd[d], exp_rd);
                end
                total++;
                if (hready[d] !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL %s ready_done: got %b want 1", tag, hready[d]);
                end
                req[d] = 1'b0;
                wr[d]  = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                total++;
                if (rsp[d] !== 1'b0 || err[d] !== 1'b0 || hready[d] !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL idle%0d: got rsp=%b err=%b hready=%b want 0 0 1",
                             d, rsp[d], err[d], hready[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; mask[d] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (hready[d] !== 1'b1 || rsp[d] !== 1'b0 || err[d] !== 1'b0 || rd[d] !== 32'd0) begin
                bad++;
                $display("[TB] FAIL reset%0d: got hready=%b rsp=%b err=%b rd=%h want 1 0 0 0",
                         d, hready[d], rsp[d], err[d], rd[d]);
            end
            model_rd[d] = 32'd0;
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                do_access(d, 1'b1, 32'(w) << 2, $urandom, 4'hF, "init");
            end
        end
        idle(1);
    endtask

    task automatic test_full_and_partial();
        do_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_full");
        idle(1);
        do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_full");
        total++;
        if (rd[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL full_word: got %h want deadbeef", rd[0]);
        end
        idle(1);
        do_access(0, 1'b1, 32'h10, 32'h00005500, 4'b0010, "st_part");
        idle(1);
        do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_part");
        total++;
        if (rd[0] !== 32'hDEAD55EF) begin
            bad++;
            $display("[TB] FAIL partial_word: got %h want dead55ef", rd[0]);
        end
        idle(1);
    endtask

    task automatic test_out_of_range();
        do_access(0, 1'b0, 32'h00001000, 32'h0, 4'h0, "ld_oor");
        total++;
        if (err[0] !== 1'b1 || rd[0] !== 32'd0) begin
            bad++;
            $display("[TB] FAIL oor_load: got err=%b rd=%h want 1 0", err[0], rd[0]);
        end
        idle(1);
        do_access(0, 1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, "st_oor");
        do_access(0, 1'b1, 32'h80000000, 32'hA5A5A5A5, 4'hF, "st_oor_hi");
        idle(1);
        do_access(0, 1'b0, 32'h0, 32'h0, 4'h0, "ld_word0");
        do_access(1, 1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, "st_oor_w0");
        do_access(1, 1'b0, 32'h0, 32'h0, 4'h0, "ld_word0_w0");
        idle(1);
    endtask

    task automatic test_mask_zero();
        do_access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, "st_mask0");
        idle(1);
        do_access(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_mask0");
        total++;
        if (rd[0] !== 32'hDEAD55EF) begin
            bad++;
            $display("[TB] FAIL mask_zero: got %h want dead55ef", rd[0]);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        do_access(1, 1'b1, 32'h4, v, 4'hF, "b2b_st");
        do_access(1, 1'b0, 32'h4, 32'h0, 4'h0, "b2b_ld");
        total++;
        if (rd[1] !== v) begin
            bad++;
            $display("[TB] FAIL b2b_raw: got %h want %h", rd[1], v);
        end
        v = $urandom;
        do_access(0, 1'b1, 32'h4, v, 4'hF, "b2b_st_w2");
        do_access(0, 1'b0, 32'h4, 32'h0, 4'h0, "b2b_ld_w2");
        total++;
        if (rd[0] !== v) begin
            bad++;
            $display("[TB] FAIL b2b_raw_w2: got %h want %h", rd[0], v);
        end
        idle(1);
    endtask

    // Reset on the first busy cycle, then on the busy cycle whose edge would
    // have committed the store; both stores must vanish.
    task automatic test_reset_busy();
        logic [31:0] old;
        old = model_mem[0][2];
        for (int late = 0; late < 2; late++) begin
            req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h12345678; mask[0] = 4'hF;
            @(posedge clk);
            #1;
            req[0] = 1'b0;
            if (late == 1) begin
                @(posedge clk);
                #1;
            end
            total++;
            if (hready[0] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rst_busy%0d_pre: got hready=%b want 0", late, hready[0]);
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if (hready[0] !== 1'b1 || rsp[0] !== 1'b0 || rd[0] !== 32'd0) begin
                bad++;
                $display("[TB] FAIL rst_busy%0d_post: got hready=%b rsp=%b rd=%h want 1 0 0",
                         late, hready[0], rsp[0], rd[0]);
            end
            rst = 1'b0;
            model_rd[0] = 32'd0;
            model_rd[1] = 32'd0;
            idle(1);
            do_access(0, 1'b0, 32'h8, 32'h0, 4'h0, "rst_busy_ld");
            total++;
            if (rd[0] !== old) begin
                bad++;
                $display("[TB] FAIL rst_busy%0d_ram: got %h want %h", late, rd[0], old);
            end
            idle(1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 7) == 0) begin
                    a = $urandom;
                    if (a[31:12] == 20'd0) a[12] = 1'b1;
                end else begin
                    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                end
                do_access(d, 1'($urandom_range(0, 1)), a, $urandom,
                          4'($urandom_range(0, 15)), "random");
                if ($urandom_range(0, 2) == 0) idle(1);
            end
            idle(1);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_full_and_partial();
        test_out_of_range();
        test_mask_zero();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
